alu_exec_unit: RTL

// - Execute-stage ALU consuming the 4-bit ALUctl code from the decode-side ALU control.
// - Single-cycle logic/arith ops; shifts iterate SHIFT_STEP bits/cycle (area-lean RV64 shifter).
// - valid/ready on both sides; sits between ID/EX register and EX/MEM stage; zero flag feeds branch unit.

---
 rtl/alu_exec_unit_pkg.sv | 32 +++
 rtl/alu_iter_shifter.sv | 75 +++++++
 rtl/alu_exec_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the execute-stage ALU: widths, ALUctl encodings,
// shifter operation kinds and the RV64 word sign-extension helper.
package alu_exec_unit_pkg;

  localparam int unsigned ALU_XLEN       = 64;
  localparam int unsigned ALU_SHIFT_STEP = 8;
  localparam int unsigned ALU_CTL_W      = 4;

  // ALUctl encodings produced by the decode-side ALU control
  localparam logic [ALU_CTL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTL_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_CTL_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_CTL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_CTL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_CTL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_CTL_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_CTL_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_CTL_W-1:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } sh_kind_e;

  // Sign-extend the low 32 bits to the full register width (RV64 *W result)
  function automatic logic [ALU_XLEN-1:0] sext_w(input logic [ALU_XLEN-1:0] x);
    return {{(ALU_XLEN-32){x[31]}}, x[31:0]};
  endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: loads an operand and shift amount on start, then shifts
// by at most SHIFT_STEP positions per cycle until the count is exhausted.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         load operand/shamt/kind (ignored while kill is high)
//   kill          abandon the in-flight shift
//   kind          SH_LL / SH_RL / SH_RA
//   operand       value to shift (already prepared for word ops)
//   shamt         total shift amount
//   busy_c        count is non-zero (shift in progress)
//   done_c        the step taken this cycle is the final one
//   step_data_c   operand after this cycle's step
module alu_iter_shifter
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN       = ALU_XLEN,
  parameter int unsigned SHIFT_STEP = ALU_SHIFT_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     kill,
  input  sh_kind_e                 kind,
  input  logic [XLEN-1:0]          operand,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic                     busy_c,
  output logic                     done_c,
  output logic [XLEN-1:0]          step_data_c
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W:0] STEP_L = (CNT_W+1)'(SHIFT_STEP);

  logic [XLEN-1:0]        data_q;
  logic [CNT_W-1:0]       cnt_q;
  sh_kind_e               kind_q;
  logic [CNT_W:0]         amt_c;
  logic signed [XLEN-1:0] sra_c;

  // Step amount = min(cnt, SHIFT_STEP) and the shifted value for this cycle
  always_comb begin
    amt_c = {1'b0, cnt_q};
    if ({1'b0, cnt_q} > STEP_L) begin
      amt_c = STEP_L;
    end
    sra_c = $signed(data_q) >>> amt_c;
    unique case (kind_q)
      SH_RL:   step_data_c = data_q >> amt_c;
      SH_RA:   step_data_c = sra_c;
      default: step_data_c = data_q << amt_c;
    endcase
  end

  assign busy_c = (cnt_q != '0);
  assign done_c = busy_c && ({1'b0, cnt_q} <= STEP_L);

  // Shift register and remaining-count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      kind_q <= SH_LL;
    end else if (kill) begin
      cnt_q <= '0;
    end else if (start) begin
      data_q <= operand;
      cnt_q  <= shamt;
      kind_q <= kind;
    end else if (busy_c) begin
      data_q <= step_data_c;
      cnt_q  <= cnt_q - amt_c[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides. Logic and
// arithmetic ops complete in one cycle; shifts run through the iterative
// shifter. Result and zero flag are held in DONE until downstream accepts.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  kill in-flight op, return to IDLE
//   in_valid / in_ready    upstream handshake (ready only in IDLE)
//   alu_ctl, is_word       operation select, RV64 *W modifier
//   op_a, op_b             operands (shamt from op_b low bits)
//   out_valid / out_ready  downstream handshake
//   result, zero           ALU result and result==0 flag
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN       = ALU_XLEN,
  parameter int unsigned SHIFT_STEP = ALU_SHIFT_STEP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_CTL_W-1:0] alu_ctl,
  input  logic                 is_word,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      result,
  output logic                 zero
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              word_q, word_d;
  logic              in_ready_q, out_valid_q;

  logic              accept_c;
  logic              is_shift_c;
  sh_kind_e          sh_kind_c;
  logic [XLEN-1:0]   sh_operand_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic [XLEN-1:0]   sum_c, diff_c, alu_c;
  logic              sh_start_c, sh_busy_c, sh_done_c;
  logic [XLEN-1:0]   sh_step_c;

  assign accept_c = in_valid && (state_q == ST_IDLE) && !flush;

  // Single-cycle datapath
  always_comb begin
    sum_c  = op_a + op_b;
    diff_c = op_a - op_b;
    unique case (alu_ctl)
      ALU_SUB:  alu_c = is_word ? sext_w(diff_c) : diff_c;
      ALU_SLT:  alu_c = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_c = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_c = op_a ^ op_b;
      ALU_OR:   alu_c = op_a | op_b;
      ALU_AND:  alu_c = op_a & op_b;
      default:  alu_c = is_word ? sext_w(sum_c) : sum_c;
    endcase
  end

  // Shift decode and operand preparation (word ops pre-extend the low half)
  always_comb begin
    is_shift_c   = 1'b0;
    sh_kind_c    = SH_LL;
    sh_operand_c = op_a;
    shamt_c      = is_word ? {1'b0, op_b[SHAMT_W-2:0]} : op_b[SHAMT_W-1:0];
    unique case (alu_ctl)
      ALU_SLL: begin
        is_shift_c = 1'b1;
      end
      ALU_SRL: begin
        is_shift_c   = 1'b1;
        sh_kind_c    = SH_RL;
        sh_operand_c = is_word ? {{(XLEN-32){1'b0}}, op_a[31:0]} : op_a;
      end
      ALU_SRA: begin
        is_shift_c   = 1'b1;
        sh_kind_c    = SH_RA;
        sh_operand_c = is_word ? sext_w(op_a) : op_a;
      end
      default: ;
    endcase
  end

  alu_iter_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (sh_start_c),
    .kill        (flush),
    .kind        (sh_kind_c),
    .operand     (sh_operand_c),
    .shamt       (shamt_c),
    .busy_c      (sh_busy_c),
    .done_c      (sh_done_c),
    .step_data_c (sh_step_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    zero_d     = zero_q;
    word_d     = word_q;
    sh_start_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          word_d = is_word;
          if (is_shift_c) begin
            sh_start_c = 1'b1;
            if (shamt_c == '0) begin
              result_d = is_word ? sext_w(sh_operand_c) : sh_operand_c;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            result_d = alu_c;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        // An idle shifter here would mean a lost count; finish rather than hang
        if (sh_done_c || !sh_busy_c) begin
          result_d = word_q ? sext_w(sh_step_c) : sh_step_c;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end

    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      zero_d = (result_d == '0);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      word_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      word_q      <= word_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
